// File: rtl/systolic_skew_sequencer_if.sv
// Handshake and buffer-read bundle between the systolic skew sequencer and its
// tile requester / operand buffers.
interface systolic_skew_sequencer_if #(
    parameter int ARRAY_DIM = 4,
    parameter int K_DEPTH   = 4
);
    localparam int IDX_WIDTH = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;

    logic                           start;
    logic                           hold_in;
    logic [ARRAY_DIM-1:0]           a_rd_en;
    logic [ARRAY_DIM*IDX_WIDTH-1:0] a_rd_addr;
    logic [ARRAY_DIM-1:0]           b_rd_en;
    logic [ARRAY_DIM*IDX_WIDTH-1:0] b_rd_addr;
    logic                           pe_en;
    logic                           acc_clr;
    logic                           cap_en;
    logic                           busy;
    logic                           done;
    logic [31:0]                    perf_cycles;

    modport master (
        output start, hold_in,
        input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        input  pe_en, acc_clr, cap_en, busy, done, perf_cycles
    );

    modport slave (
        input  start, hold_in,
        output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        output pe_en, acc_clr, cap_en, busy, done, perf_cycles
    );
endinterface

// File: rtl/systolic_skew_sequencer.sv
// Skewed operand-feed sequencer for a square systolic array (clear, feed, drain, capture).
// Optional cycle counter on perf_cycles is built only when SEQ_PERF_CNT_EN is defined.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_CLEAR   | one cycle of acc_clr, step counter reset
// S_FEED    | skewed A/B reads, step t advances unless stalled
// S_DRAIN   | ARRAY_DIM cycles of pe_en to flush the wavefront
// S_CAPTURE | one cycle of cap_en
// S_DONE    | done held until start drops
module systolic_skew_sequencer #(
    parameter int ARRAY_DIM = 4,
    parameter int K_DEPTH   = 4
) (
    input logic                     clk,
    input logic                     rst,
    systolic_skew_sequencer_if.slave bus
);
    localparam int IDX_WIDTH = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
    localparam int T_WIDTH   = $clog2(K_DEPTH + ARRAY_DIM);
    localparam int D_WIDTH   = $clog2(ARRAY_DIM + 1);
    localparam logic [T_WIDTH-1:0] T_LAST = T_WIDTH'(K_DEPTH + ARRAY_DIM - 2);
    localparam logic [T_WIDTH-1:0] T_K    = T_WIDTH'(K_DEPTH);
    localparam logic [D_WIDTH-1:0] D_LAST = D_WIDTH'(ARRAY_DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [T_WIDTH-1:0]   t, t_nxt;
    logic [D_WIDTH-1:0]   drain_cnt, drain_nxt;
    logic                 hold_q;

    logic [ARRAY_DIM-1:0]           lane_en;
    logic [ARRAY_DIM*IDX_WIDTH-1:0] lane_addr;
    logic                           pe_en, acc_clr, cap_en, busy, done;

    // hold_in is registered so no output depends combinationally on an input;
    // a FEED cycle is a stall cycle when hold_in was high in the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            t         <= '0;
            drain_cnt <= '0;
            hold_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            t         <= t_nxt;
            drain_cnt <= drain_nxt;
            hold_q    <= bus.hold_in;
        end
    end

    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        drain_nxt = drain_cnt;
        lane_en   = '0;
        lane_addr = '0;
        pe_en     = 1'b0;
        acc_clr   = 1'b0;
        cap_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                busy      = 1'b1;
                acc_clr   = 1'b1;
                t_nxt     = '0;
                state_nxt = S_FEED;
            end
            S_FEED: begin
                busy = 1'b1;
                if (!hold_q) begin
                    pe_en = 1'b1;
                    // lane i reads index t-i only inside its K_DEPTH-wide window
                    for (int i = 0; i < ARRAY_DIM; i++) begin
                        if ((t >= T_WIDTH'(i)) && ((t - T_WIDTH'(i)) < T_K)) begin
                            lane_en[i] = 1'b1;
                            lane_addr[i*IDX_WIDTH +: IDX_WIDTH] = IDX_WIDTH'(t - T_WIDTH'(i));
                        end
                    end
                    if (t == T_LAST) begin
                        t_nxt     = '0;
                        drain_nxt = D_LAST;
                        state_nxt = S_DRAIN;
                    end else begin
                        t_nxt = t + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                busy  = 1'b1;
                pe_en = 1'b1;
                if (drain_cnt == '0) state_nxt = S_CAPTURE;
                else                 drain_nxt = drain_cnt - 1'b1;
            end
            S_CAPTURE: begin
                busy      = 1'b1;
                cap_en    = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (!bus.start) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.a_rd_en   = lane_en;
    assign bus.a_rd_addr = lane_addr;
    assign bus.b_rd_en   = lane_en;
    assign bus.b_rd_addr = lane_addr;
    assign bus.pe_en     = pe_en;
    assign bus.acc_clr   = acc_clr;
    assign bus.cap_en    = cap_en;
    assign bus.busy      = busy;
    assign bus.done      = done;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cnt;

    // counts only in busy states, so the value stays frozen through DONE and IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if ((state == S_IDLE) && (state_nxt == S_CLEAR)) begin
            perf_cnt <= '0;
        end else if (busy && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign bus.perf_cycles = perf_cnt;
`else
    assign bus.perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_skew_sequencer.sv
// Self-checking bench: schedule-based reference model for ARRAY_DIM=4/K_DEPTH=4 plus
// a directed table for the ARRAY_DIM=2/K_DEPTH=1 corner.
module tb_systolic_skew_sequencer;
    localparam int AD    = 4;
    localparam int KD    = 4;
    localparam int IW    = 2;
    localparam int T_END = KD + AD - 2;

    typedef struct {
        logic [AD-1:0]    en;
        logic [AD*IW-1:0] addr;
        logic             pe, clr, cap, busy, done;
        logic [31:0]      perf;
        bit               chk_perf;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   last_perf = 0;
    logic [AD-1:0]    obs_en [128];
    logic [AD*IW-1:0] obs_addr [128];

    always #5 clk = ~clk;

    systolic_skew_sequencer_if #(.ARRAY_DIM(AD), .K_DEPTH(KD)) sif ();
    systolic_skew_sequencer_if #(.ARRAY_DIM(2),  .K_DEPTH(1))  sif2 ();

    systolic_skew_sequencer #(.ARRAY_DIM(AD), .K_DEPTH(KD)) dut (
        .clk(clk), .rst(rst), .bus(sif)
    );
    systolic_skew_sequencer #(.ARRAY_DIM(2), .K_DEPTH(1)) dut2 (
        .clk(clk), .rst(rst2), .bus(sif2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t blank();
        rec_t r;
        r.en = '0; r.addr = '0; r.pe = 0; r.clr = 0; r.cap = 0;
        r.busy = 0; r.done = 0; r.perf = 0; r.chk_perf = 0;
        return r;
    endfunction

    function automatic rec_t feed_rec(input int t, input bit stalled);
        rec_t r = blank();
        r.busy = 1;
        r.pe   = !stalled;
        for (int i = 0; i < AD; i++) begin
            if (!stalled && t >= i && t <= i + KD - 1) begin
                r.en[i] = 1'b1;
                r.addr[i*IW +: IW] = IW'(t - i);
            end
        end
        return r;
    endfunction

    task automatic check_rec(input rec_t r);
        chk("a_rd_en",   32'(sif.a_rd_en),   32'(r.en));
        chk("a_rd_addr", 32'(sif.a_rd_addr), 32'(r.addr));
        chk("b_rd_en",   32'(sif.b_rd_en),   32'(r.en));
        chk("b_rd_addr", 32'(sif.b_rd_addr), 32'(r.addr));
        chk("pe_en",     32'(sif.pe_en),     32'(r.pe));
        chk("acc_clr",   32'(sif.acc_clr),   32'(r.clr));
        chk("cap_en",    32'(sif.cap_en),    32'(r.cap));
        chk("busy",      32'(sif.busy),      32'(r.busy));
        chk("done",      32'(sif.done),      32'(r.done));
`ifdef SEQ_PERF_CNT_EN
        if (r.chk_perf) chk("perf_cycles", sif.perf_cycles, r.perf);
`else
        chk("perf_cycles", sif.perf_cycles, 32'd0);
`endif
    endtask

    // Builds the expected cycle-by-cycle schedule of one tile from the phase lengths,
    // then drives start/hold_in and compares every cycle. Entered in an IDLE cycle.
    task automatic run_tile(input int stall_pct, input int force_at, input int force_len,
                            input int done_hold, input bit noisy, output int first_done);
        rec_t q[$];
        rec_t r;
        bit   hs[128];
        bit   ss[128];
        int   t, c, total;
        for (int i = 0; i < 128; i++) begin
            hs[i] = ($urandom_range(0, 99) < stall_pct);
            ss[i] = noisy && ($urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < force_len; i++) hs[force_at + i] = 1'b1;
        ss[0] = 1'b1;
        r = blank(); r.perf = last_perf; r.chk_perf = 1; q.push_back(r);
        r = blank(); r.busy = 1; r.clr = 1; q.push_back(r);
        t = 0;
        c = 2;
        while (t <= T_END) begin
            if (c > 60) hs[c-1] = 1'b0;
            q.push_back(feed_rec(t, hs[c-1]));
            if (!hs[c-1]) t++;
            c++;
        end
        for (int d = 0; d < AD; d++) begin
            r = blank(); r.busy = 1; r.pe = 1; q.push_back(r); c++;
        end
        r = blank(); r.busy = 1; r.cap = 1; q.push_back(r); c++;
        total = c - 1;
`ifdef SEQ_PERF_CNT_EN
        last_perf = total;
`else
        last_perf = 0;
`endif
        for (int d = 0; d <= done_hold; d++) begin
            r = blank(); r.done = 1; r.perf = last_perf; r.chk_perf = 1; q.push_back(r);
            ss[c + d] = (d < done_hold);
        end
        c += done_hold + 1;
        r = blank(); r.perf = last_perf; r.chk_perf = 1; q.push_back(r);
        ss[c] = 1'b0;

        first_done = -1;
        for (int k = 0; k < q.size(); k++) begin
            check_rec(q[k]);
            obs_en[k]   = sif.a_rd_en;
            obs_addr[k] = sif.a_rd_addr;
            if (first_done < 0 && sif.done === 1'b1) first_done = k;
            sif.hold_in = hs[k];
            sif.start   = ss[k];
            @(posedge clk); #1;
        end
        sif.start   = 1'b0;
        sif.hold_in = 1'b0;
    endtask

    initial begin
        int fd;
        rec_t z;
        int e_en[9]   = '{0, 0, 1, 2, 0, 0, 0, 0, 0};
        int e_pe[9]   = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
        int e_clr[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        int e_cap[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        int e_busy[9] = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
        int e_done[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        int perf2;

        sif.start = 0; sif.hold_in = 0;
        sif2.start = 0; sif2.hold_in = 0;
        z = blank(); z.chk_perf = 1;

        sif.start = 1; sif.hold_in = 1;
        repeat (2) @(posedge clk);
        #1;
        check_rec(z);
        rst = 0; sif.start = 0; sif.hold_in = 0;
        @(posedge clk); #1;

        run_tile(0, 0, 0, 0, 0, fd);
        chk("done_latency", 32'(fd), 32'd14);
        chk("t3_rd_en",   32'(obs_en[5]),   32'h0F);
        chk("t3_rd_addr", 32'(obs_addr[5]), 32'h1B);
        chk("t5_rd_en",   32'(obs_en[7]),   32'h0C);
        chk("t5_rd_addr", 32'(obs_addr[7]), 32'hB0);

        run_tile(0, 3, 3, 0, 0, fd);
        chk("stall_done_latency", 32'(fd), 32'd17);
`ifdef SEQ_PERF_CNT_EN
        chk("stall_perf", sif.perf_cycles, 32'd16);
`endif

        run_tile(0, 0, 0, 5, 1, fd);
        chk("noisy_done_latency", 32'(fd), 32'd14);

        for (int n = 0; n < 6; n++) begin
            run_tile(int'($urandom_range(0, 50)), 0, 0, int'($urandom_range(0, 5)), 1, fd);
        end

        // reset in cycle 6 while mid-FEED and stalled
        sif.start = 1;
        @(posedge clk); #1;
        sif.start = 0;
        repeat (2) begin @(posedge clk); #1; end
        sif.hold_in = 1;
        repeat (3) begin @(posedge clk); #1; end
        chk("busy_before_rst", 32'(sif.busy), 32'd1);
        rst = 1; sif.start = 1;
        @(posedge clk); #1;
        check_rec(z);
        rst = 0; sif.start = 0; sif.hold_in = 0;
        last_perf = 0;
        @(posedge clk); #1;
        check_rec(z);
        run_tile(0, 0, 0, 1, 0, fd);
        chk("post_rst_done_latency", 32'(fd), 32'd14);

        run_tile(30, 0, 0, 2, 1, fd);

        // ARRAY_DIM=2, K_DEPTH=1 corner
        rst2 = 0;
        @(posedge clk); #1;
`ifdef SEQ_PERF_CNT_EN
        perf2 = 6;
`else
        perf2 = 0;
`endif
        for (int k = 0; k < 9; k++) begin
            chk("c_a_rd_en",   32'(sif2.a_rd_en),   32'(e_en[k]));
            chk("c_b_rd_en",   32'(sif2.b_rd_en),   32'(e_en[k]));
            chk("c_a_rd_addr", 32'(sif2.a_rd_addr), 32'd0);
            chk("c_b_rd_addr", 32'(sif2.b_rd_addr), 32'd0);
            chk("c_pe_en",     32'(sif2.pe_en),     32'(e_pe[k]));
            chk("c_acc_clr",   32'(sif2.acc_clr),   32'(e_clr[k]));
            chk("c_cap_en",    32'(sif2.cap_en),    32'(e_cap[k]));
            chk("c_busy",      32'(sif2.busy),      32'(e_busy[k]));
            chk("c_done",      32'(sif2.done),      32'(e_done[k]));
`ifdef SEQ_PERF_CNT_EN
            if (e_busy[k] == 0) chk("c_perf", sif2.perf_cycles, (k >= 7) ? 32'(perf2) : 32'd0);
`else
            chk("c_perf", sif2.perf_cycles, 32'(perf2));
`endif
            sif2.start = (k == 0);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_skew_sequencer.md
SYSTOLIC_SKEW_SEQUENCER -- requirements
Module: systolic_skew_sequencer

Interface
REQ-001 SHALL have parameter ARRAY_DIM, default 4, giving the PE rows and columns of the square systolic array (2..16).
REQ-002 SHALL have parameter K_DEPTH, default 4, giving the operand vector length per tile (1..256).
REQ-003 SHALL derive localparam IDX_WIDTH = max(1, clog2(K_DEPTH)).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  level request to run one tile; sampled in IDLE and DONE only.
REQ-007 hold_in  input  1  operand buffers not ready; stalls the FEED phase.
REQ-008 a_rd_en  output  ARRAY_DIM  per-row A-buffer read enable.
REQ-009 a_rd_addr  output  ARRAY_DIM*IDX_WIDTH  per-row A index; row i occupies bits [i*IDX_WIDTH +: IDX_WIDTH].
REQ-010 b_rd_en  output  ARRAY_DIM  per-column B-buffer read enable.
REQ-011 b_rd_addr  output  ARRAY_DIM*IDX_WIDTH  per-column B index; same packing as a_rd_addr.
REQ-012 pe_en  output  1  array advance enable.
REQ-013 acc_clr  output  1  clear of all PE accumulators.
REQ-014 cap_en  output  1  result-capture strobe.
REQ-015 busy  output  1  high in every state except IDLE and DONE.
REQ-016 done  output  1  tile complete.
REQ-017 perf_cycles  output  32  cycle count of the last run (see Configuration).

Function
REQ-018 States: IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE. All outputs SHALL be registered or decoded from registered state and counters only; no combinational path from any input to any output.
REQ-019 IDLE SHALL go to CLEAR when start=1. Otherwise it stays in IDLE.
REQ-020 CLEAR SHALL last 1 cycle with acc_clr=1, set step counter t=0, and go to FEED.
REQ-021 In FEED, row i SHALL be active when i <= t <= i+K_DEPTH-1: a_rd_en[i]=1 and a_rd_addr row i = t-i. Column j SHALL use the same rule for b_rd_en[j] and b_rd_addr. Inactive lanes SHALL drive en=0 and addr=0.
REQ-022 In FEED with hold_in=0: pe_en=1 and t increments. With hold_in=1: t holds, and all rd_en and pe_en are 0.
REQ-023 FEED SHALL end after the unstalled cycle with t = K_DEPTH+ARRAY_DIM-2, then go to DRAIN.
REQ-024 DRAIN SHALL last exactly ARRAY_DIM cycles with pe_en=1. hold_in SHALL be ignored. The state then goes to CAPTURE.
REQ-025 CAPTURE SHALL last 1 cycle with cap_en=1 and pe_en=0, then go to DONE.
REQ-026 DONE SHALL hold done=1 and stay in DONE while start=1. It SHALL return to IDLE on the first cycle start=0. start is never reissued from DONE.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 Unstalled latency: CLEAR + (K_DEPTH+ARRAY_DIM-1) FEED + ARRAY_DIM DRAIN + 1 CAPTURE cycles. done SHALL rise at the edge that follows.
REQ-029 Address arithmetic SHALL use an internal counter width that holds K_DEPTH+ARRAY_DIM-1 without wrap. The t-i subtraction SHALL never reach an output unguarded.

Reset
REQ-030 When rst=1 at a clock edge, the state SHALL become IDLE, t and all internal counters SHALL become 0, and every output SHALL be 0 (perf_cycles included). This applies from any state, including mid-FEED and mid-stall.
REQ-031 rst SHALL take priority over start and hold_in in the same cycle.

Configuration
REQ-032 Macro SEQ_PERF_CNT_EN SHALL control the performance counter.
- Defined: a 32-bit counter clears on entry to CLEAR and increments every cycle in CLEAR, FEED (stalled or not), DRAIN and CAPTURE, saturating at 2^32-1. perf_cycles SHALL present the value frozen on entry to DONE and hold it until the next CLEAR.
- Undefined: perf_cycles SHALL be constant 0 and no counter logic is synthesized.

Verification
REQ-033 ARRAY_DIM=4, K_DEPTH=4: start pulse in cycle 0 -> acc_clr in cycle 1, FEED in cycles 2-8, DRAIN in 9-12, cap_en in 13, done=1 from cycle 14 while start=1.
REQ-034 Same config, FEED step t=3 -> a_rd_en=4'b1111 with row addresses {0,1,2,3} (row3..row0). At t=5 -> a_rd_en=4'b1100 with row3 addr=2, row2 addr=3. b_rd_en and b_rd_addr SHALL match.
REQ-035 hold_in=1 for 3 cycles at t=2 -> rd_en=0, pe_en=0 and t=2 for those 3 cycles; done is delayed to cycle 17. With SEQ_PERF_CNT_EN defined, perf_cycles=16.
REQ-036 rst=1 in cycle 6 (mid-FEED) -> all outputs 0 in cycle 7 and state IDLE. A new start after reset yields the REQ-033 timing offset accordingly.
REQ-037 start pulses during busy -> no effect. start held high through DONE for 5 cycles -> done stays 1. start low -> IDLE next cycle, done=0.
REQ-038 ARRAY_DIM=2, K_DEPTH=1 corner case -> FEED lasts 2 cycles (t=0: lane0 only; t=1: lane1 only, addr 0). Without SEQ_PERF_CNT_EN, perf_cycles=0 throughout.
